// File: rtl/q_action_select_if.sv
// Bundle of request, Q-table read and response signals for q_action_select.
// The epsilon / resp_explored pair exists only when EPSILON_EXPLORE_EN is defined.
interface q_action_select_if #(
  parameter int STATE_BITS  = 4,
  parameter int ACTION_BITS = 2,
  parameter int DATA_WIDTH  = 16
);
  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // a response transfers on the edge where resp_valid && resp_ready. A valid side holds
  // its payload stable until the transfer; ready may be raised or dropped freely.
  logic                              req_valid;
  logic                              req_ready;
  logic [STATE_BITS-1:0]             req_state;
  logic                              rd_en;
  logic [STATE_BITS+ACTION_BITS-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]             rd_data;
  logic                              resp_valid;
  logic                              resp_ready;
  logic [ACTION_BITS-1:0]            resp_action;
  logic [DATA_WIDTH-1:0]             resp_q;
`ifdef EPSILON_EXPLORE_EN
  logic [7:0]                        epsilon;
  logic                              resp_explored;

  modport slave (
    input  req_valid, req_state, rd_data, resp_ready, epsilon,
    output req_ready, rd_en, rd_addr, resp_valid, resp_action, resp_q, resp_explored
  );
  modport master (
    output req_valid, req_state, rd_data, resp_ready, epsilon,
    input  req_ready, rd_en, rd_addr, resp_valid, resp_action, resp_q, resp_explored
  );
`else
  modport slave (
    input  req_valid, req_state, rd_data, resp_ready,
    output req_ready, rd_en, rd_addr, resp_valid, resp_action, resp_q
  );
  modport master (
    output req_valid, req_state, rd_data, resp_ready,
    input  req_ready, rd_en, rd_addr, resp_valid, resp_action, resp_q
  );
`endif
endinterface

// File: rtl/q_action_select.sv
// Greedy action selector: scans Q(s,0..N-1) through a 1-cycle-latency RAM port, returns argmax.
// Optional epsilon-greedy exploration via LFSR when EPSILON_EXPLORE_EN is defined.
module q_action_select #(
  parameter int STATE_BITS  = 4,
  parameter int ACTION_BITS = 2,
  parameter int DATA_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  q_action_select_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int NUM_ACTIONS = 2**ACTION_BITS;
  localparam logic [ACTION_BITS-1:0] LAST_IDX = ACTION_BITS'(NUM_ACTIONS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_e;

  state_e                         state_q, state_d;
  logic [STATE_BITS-1:0]          st_q, st_d;
  logic [ACTION_BITS-1:0]         idx_q, idx_d;
  logic [ACTION_BITS-1:0]         cmp_idx_q, cmp_idx_d;
  logic                           data_vld_q, data_vld_d;
  logic signed [DATA_WIDTH-1:0]   max_q, max_d;
  logic [ACTION_BITS-1:0]         arg_q, arg_d;
  logic [ACTION_BITS-1:0]         resp_act_q, resp_act_d;
  logic [DATA_WIDTH-1:0]          resp_val_q, resp_val_d;
  logic                           rd_en;
`ifdef EPSILON_EXPLORE_EN
  logic [15:0]                    lfsr_q, lfsr_d;
  logic                           explore_q, explore_d;
  logic [ACTION_BITS-1:0]         rand_act_q, rand_act_d;
  logic [DATA_WIDTH-1:0]          rand_val_q, rand_val_d;
  logic                           explored_q, explored_d;
`endif

  assign rd_en            = (state_q == SCAN);
  assign bus.rd_en        = rd_en;
  // Address is built from held registers, so it keeps its last value while rd_en is low.
  assign bus.rd_addr      = {st_q, idx_q};
  assign bus.req_ready    = rst_n && (state_q == IDLE);
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_action  = resp_act_q;
  assign bus.resp_q       = resp_val_q;
  assign dbg_state        = state_q;
`ifdef EPSILON_EXPLORE_EN
  assign bus.resp_explored = explored_q;
`endif

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    idx_d      = idx_q;
    cmp_idx_d  = idx_q;
    data_vld_d = rd_en;
    max_d      = max_q;
    arg_d      = arg_q;
    resp_act_d = resp_act_q;
    resp_val_d = resp_val_q;
`ifdef EPSILON_EXPLORE_EN
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    explore_d  = explore_q;
    rand_act_d = rand_act_q;
    rand_val_d = rand_val_q;
    explored_d = explored_q;
`endif

    // Data returned this cycle belongs to the read issued last cycle (index cmp_idx_q).
    // Index 0 is always the first return, so it seeds max/argmax unconditionally.
    if (data_vld_q) begin
      if ((cmp_idx_q == '0) || ($signed(bus.rd_data) > max_q)) begin
        max_d = $signed(bus.rd_data);
        arg_d = cmp_idx_q;
      end
`ifdef EPSILON_EXPLORE_EN
      if (cmp_idx_q == rand_act_q) rand_val_d = bus.rd_data;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          st_d    = bus.req_state;
          idx_d   = '0;
          state_d = SCAN;
`ifdef EPSILON_EXPLORE_EN
          explore_d  = (lfsr_q[7:0] < bus.epsilon);
          rand_act_d = lfsr_q[8 +: ACTION_BITS];
`endif
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      DRAIN: begin
        state_d    = RESP;
        resp_act_d = arg_d;
        resp_val_d = max_d;
`ifdef EPSILON_EXPLORE_EN
        explored_d = explore_q;
        if (explore_q) begin
          resp_act_d = rand_act_q;
          resp_val_d = rand_val_d;
        end
`endif
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      st_q       <= '0;
      idx_q      <= '0;
      cmp_idx_q  <= '0;
      data_vld_q <= 1'b0;
      max_q      <= '0;
      arg_q      <= '0;
      resp_act_q <= '0;
      resp_val_q <= '0;
`ifdef EPSILON_EXPLORE_EN
      lfsr_q     <= 16'hACE1;
      explore_q  <= 1'b0;
      rand_act_q <= '0;
      rand_val_q <= '0;
      explored_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      idx_q      <= idx_d;
      cmp_idx_q  <= cmp_idx_d;
      data_vld_q <= data_vld_d;
      max_q      <= max_d;
      arg_q      <= arg_d;
      resp_act_q <= resp_act_d;
      resp_val_q <= resp_val_d;
`ifdef EPSILON_EXPLORE_EN
      lfsr_q     <= lfsr_d;
      explore_q  <= explore_d;
      rand_act_q <= rand_act_d;
      rand_val_q <= rand_val_d;
      explored_q <= explored_d;
`endif
    end
  end
endmodule
